// File: rtl/upsample_fifo_reader_if.sv
// Handshake bundle between the Gaussian-stage FIFO, the 2x upsampling reader and the
// next pipeline stage. The master modport is the reader's view, slave is the environment.
// Optional end-of-line flags exist only when UPSAMPLE_EOL_EN is defined.
interface upsample_fifo_reader_if #(
    parameter int unsigned DATA_W = 8
);
    // FIFO read side
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic              fifo_valid;
    logic [DATA_W-1:0] fifo_dout;
    // Upsampled output stream
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              row_dup;
`ifdef UPSAMPLE_EOL_EN
    logic              out_eol;
    logic              out_eof_pair;
`endif

    modport master (
        input  fifo_empty,
        output fifo_rd_en,
        input  fifo_valid,
        input  fifo_dout,
        output out_valid,
        output out_data,
        input  out_ready,
`ifdef UPSAMPLE_EOL_EN
        output out_eol,
        output out_eof_pair,
`endif
        output row_dup
    );

    modport slave (
        output fifo_empty,
        input  fifo_rd_en,
        output fifo_valid,
        output fifo_dout,
        input  out_valid,
        input  out_data,
        output out_ready,
`ifdef UPSAMPLE_EOL_EN
        input  out_eol,
        input  out_eof_pair,
`endif
        input  row_dup
    );
endinterface

// File: rtl/upsample_fifo_reader.sv
// 2x nearest-neighbour upsampler on the read side of the Gaussian-stage FIFO.
// Each source pixel is emitted twice (live row), then the whole row is replayed
// twice per pixel from a single-row line buffer (row_dup=1).
// Optional macro UPSAMPLE_EOL_EN adds out_eol / out_eof_pair row markers.
module upsample_fifo_reader #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned IN_WIDTH = 320,
    parameter int unsigned COL_W    = 9
) (
    input  logic                  clk,
    input  logic                  rst,     // asynchronous, active-low
    upsample_fifo_reader_if.master bus_io
);

    localparam logic [COL_W-1:0] LastCol = COL_W'(IN_WIDTH - 1);

    typedef enum logic [0:0] {
        StLive,
        StReplay
    } state_e;

    state_e              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic                dup_q, dup_d;
    logic [DATA_W-1:0]   pix_q, pix_d;
    logic                pix_vld_q, pix_vld_d;
    logic                rd_pend_q, rd_pend_d;
    logic [DATA_W-1:0]   linebuf_q [IN_WIDTH];

    logic                rd_en;
    logic                out_valid;
    logic [DATA_W-1:0]   out_data;
    logic                hs;
    logic                lb_we;

    // Output decode: live rows come from the pixel register, replays from the line buffer
    always_comb begin
        rd_en     = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        unique case (state_q)
            StLive: begin
                // Gated by reset so no pop can be issued while held in reset
                rd_en     = rst & ~bus_io.fifo_empty & ~pix_vld_q & ~rd_pend_q;
                out_valid = pix_vld_q;
                out_data  = pix_q;
            end
            StReplay: begin
                out_valid = 1'b1;
                out_data  = linebuf_q[col_q];
            end
            default: ;
        endcase
    end

    assign hs    = out_valid & bus_io.out_ready;
    assign lb_we = bus_io.fifo_valid & rd_pend_q;

    // Next-state: FIFO read tracking, pixel capture and dup/col/state advance on handshakes
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        dup_d     = dup_q;
        pix_d     = pix_q;
        pix_vld_d = pix_vld_q;
        rd_pend_d = rd_pend_q;

        if (rd_en) begin
            rd_pend_d = 1'b1;
        end

        // Data returning without an outstanding request is stale and dropped
        if (lb_we) begin
            pix_d     = bus_io.fifo_dout;
            pix_vld_d = 1'b1;
            rd_pend_d = 1'b0;
        end

        if (hs) begin
            if (!dup_q) begin
                dup_d = 1'b1;
            end else begin
                dup_d = 1'b0;
                if (state_q == StLive) begin
                    pix_vld_d = 1'b0;
                end
                if (col_q == LastCol) begin
                    col_d   = '0;
                    state_d = (state_q == StLive) ? StReplay : StLive;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
        end
    end

    // Control and pixel registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StLive;
            col_q     <= '0;
            dup_q     <= 1'b0;
            pix_q     <= '0;
            pix_vld_q <= 1'b0;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            dup_q     <= dup_d;
            pix_q     <= pix_d;
            pix_vld_q <= pix_vld_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    // Line buffer capture; only written in LIVE, so replay reads are never disturbed
    always_ff @(posedge clk) begin
        if (lb_we) begin
            linebuf_q[col_q] <= bus_io.fifo_dout;
        end
    end

    assign bus_io.fifo_rd_en = rd_en;
    assign bus_io.out_valid  = out_valid;
    assign bus_io.out_data   = out_data;
    assign bus_io.row_dup    = (state_q == StReplay);

`ifdef UPSAMPLE_EOL_EN
    logic eol;
    assign eol                 = out_valid & dup_q & (col_q == LastCol);
    assign bus_io.out_eol      = eol;
    assign bus_io.out_eof_pair = eol & (state_q == StReplay);
`endif

endmodule

// File: tb/tb_upsample_fifo_reader.sv
// Self-checking bench for upsample_fifo_reader (IN_WIDTH=4): table-driven row vectors
// plus hand sequences for latency, backpressure and mid-replay reset. A behavioural FIFO
// feeds the DUT; a reference model queues the expected beats when pixels are pushed.
module tb_upsample_fifo_reader;

    localparam int unsigned DW = 8;
    localparam int unsigned W  = 4;
    localparam int unsigned CW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    upsample_fifo_reader_if #(.DATA_W(DW)) bus ();

    upsample_fifo_reader #(
        .DATA_W  (DW),
        .IN_WIDTH(W),
        .COL_W   (CW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus)
    );

    // Behavioural FIFO: data valid one cycle after an accepted pop
    logic [7:0] fmem [256];
    logic [7:0] fwr = 8'd0;
    logic [7:0] frd = 8'd0;
    assign bus.fifo_empty = (frd == fwr);

    always @(posedge clk) begin
        bus.fifo_valid <= bus.fifo_rd_en && !bus.fifo_empty;
        if (bus.fifo_rd_en && !bus.fifo_empty) begin
            bus.fifo_dout <= fmem[frd];
            frd           <= frd + 8'd1;
        end
    end

    typedef struct {
        logic [7:0] data;
        logic       dup;
        logic       eol;
        logic       eof;
    } beat_t;

    typedef struct {
        logic [3:0][7:0] pix;
        int              ready_pct;
        int              exp_beats;
        int              exp_rd;
    } vec_t;

    beat_t      exp_q [$];
    logic [7:0] row_buf [W];
    int         row_cnt = 0;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   beats    = 0;
    int   rd_cnt   = 0;
    int   ready_pct = 100;
    int   last_rd_cyc = -1;
    int   first_val_cyc = -1;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: live pair per pixel, replay of the row once it is complete
    task automatic push_pix(input logic [7:0] v);
        fmem[fwr] = v;
        fwr       = fwr + 8'd1;
        exp_q.push_back('{v, 1'b0, 1'b0, 1'b0});
        exp_q.push_back('{v, 1'b0, (row_cnt == W - 1), 1'b0});
        row_buf[row_cnt] = v;
        row_cnt++;
        if (row_cnt == W) begin
            for (int i = 0; i < W; i++) begin
                exp_q.push_back('{row_buf[i], 1'b1, 1'b0, 1'b0});
                exp_q.push_back('{row_buf[i], 1'b1, (i == W - 1), (i == W - 1)});
            end
            row_cnt = 0;
        end
    endtask

    // One cycle: drive ready, sample this cycle's outputs, advance to the next negedge
    task automatic step();
        beat_t e;
        bus.out_ready = (ready_pct > 0) && ($urandom_range(0, 99) < ready_pct);
        #1;
        if (bus.fifo_rd_en) begin
            rd_cnt++;
            last_rd_cyc = cyc;
        end
        if (bus.out_valid && first_val_cyc < 0) first_val_cyc = cyc;
        if (prev_stall) begin
            check("hold_valid", bus.out_valid, 1);
            check("hold_data", bus.out_data, prev_data);
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
        if (bus.out_valid && bus.out_ready) begin
            beats++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL extra_beat: got data %0h, expected no beat (cycle %0d)",
                         bus.out_data, cyc);
            end else begin
                e = exp_q.pop_front();
                check("out_data", bus.out_data, e.data);
                check("row_dup", bus.row_dup, e.dup);
`ifdef UPSAMPLE_EOL_EN
                check("out_eol", bus.out_eol, e.eol);
                check("out_eof_pair", bus.out_eof_pair, e.eof);
`endif
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain(input string name, input int limit);
        int n = 0;
        while (exp_q.size() > 0 && n < limit) begin
            step();
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        prev_stall = 1'b0;
        exp_q.delete();
        row_cnt = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    vec_t vecs [4];

    initial begin
        int n;
        logic ok_v, ok_d, ok_r;

        vecs[0].pix       = {8'd40, 8'd30, 8'd20, 8'd10};
        vecs[0].ready_pct = 100;
        for (int i = 1; i < 4; i++) begin
            for (int j = 0; j < 4; j++) vecs[i].pix[j] = 8'($urandom_range(0, 255));
            vecs[i].ready_pct = 50;
        end
        for (int i = 0; i < 4; i++) begin
            vecs[i].exp_beats = 4 * W;
            vecs[i].exp_rd    = W;
        end

        // Reset state
        rst           = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_valid", bus.out_valid, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_dup", bus.row_dup, 0);
        check("rst_rd_en", bus.fifo_rd_en, 0);
        check("rst_col", dut.col_q, 0);
        @(negedge clk);
        rst = 1'b1;

        // Table: one full source row per vector
        for (int v = 0; v < 4; v++) begin
            ready_pct = vecs[v].ready_pct;
            beats     = 0;
            rd_cnt    = 0;
            for (int j = 0; j < 4; j++) push_pix(vecs[v].pix[j]);
            n = 0;
            while (beats < vecs[v].exp_beats && n < 2000) begin
                step();
                n++;
            end
            repeat (3) step();
            check("vec_beats", beats, vecs[v].exp_beats);
            check("vec_rd_pulses", rd_cnt, vecs[v].exp_rd);
            check("vec_sb_empty", exp_q.size(), 0);
            check("vec_col_end", dut.col_q, 0);
            check("vec_idle", bus.out_valid, 0);
        end

        // Latency with a single pixel and an empty FIFO afterwards
        do_reset();
        ready_pct     = 100;
        beats         = 0;
        first_val_cyc = -1;
        last_rd_cyc   = -1;
        push_pix(8'h55);
        n = 0;
        while (first_val_cyc < 0 && n < 20) begin
            step();
            n++;
        end
        check("latency", first_val_cyc - last_rd_cyc, 2);
        n = 0;
        while (beats < 2 && n < 20) begin
            step();
            n++;
        end
        check("single_beats", beats, 2);
        check("single_idle", bus.out_valid, 0);
        check("single_col", dut.col_q, 1);
        check("single_dup", bus.row_dup, 0);

        // Backpressure on the first beat of 0xA3 while the FIFO still holds data
        ready_pct = 0;
        push_pix(8'hA3);
        push_pix(8'hB4);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            step();
            n++;
        end
        ok_v = 1'b1;
        ok_d = 1'b1;
        ok_r = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (!bus.out_valid) ok_v = 1'b0;
            if (bus.out_data !== 8'hA3) ok_d = 1'b0;
            if (bus.fifo_rd_en) ok_r = 1'b0;
            #1;
            step();
        end
        check("bp_valid_held", ok_v, 1);
        check("bp_data_held", ok_d, 1);
        check("bp_no_read", ok_r, 1);
        ready_pct = 100;
        push_pix(8'hC5);
        drain("bp_drain", 200);

        // Reset in the middle of a replay row
        do_reset();
        ready_pct = 100;
        for (int j = 1; j <= 4; j++) push_pix(8'(j));
        n = 0;
        while (!(bus.row_dup && dut.col_q == 2'd2) && n < 200) begin
            step();
            n++;
        end
        check("reach_replay_col2", {bus.row_dup, dut.col_q}, {1'b1, 2'd2});
        rst        = 1'b0;
        prev_stall = 1'b0;
        exp_q.delete();
        row_cnt = 0;
        push_pix(8'h07);
        #1;
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_dup", bus.row_dup, 0);
        check("mid_rst_rd_en", bus.fifo_rd_en, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            step();
            n++;
        end
        check("post_rst_col", dut.col_q, 0);
        check("post_rst_data", bus.out_data, 8'h07);
        check("post_rst_dup", bus.row_dup, 0);
        push_pix(8'h08);
        push_pix(8'h09);
        push_pix(8'h0A);
        drain("post_rst_drain", 200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/upsample_fifo_reader.md
Name: upsample_fifo_reader

Overview:
- Read-side consumer of the Gaussian-stage FIFO.
- Pops filtered 8-bit pixels with the FIFO's rd_en/valid/empty handshake.
- Emits a 2x nearest-neighbour upsampled stream (each pixel twice horizontally, each row twice vertically) to the next SIFT pipeline stage over a valid/ready interface.
- A single-row line buffer holds the current source row for the vertical replay.

Parameters:
- DATA_W, 8, pixel width in bits.
- IN_WIDTH, 320, source row length in pixels; output row is 2*IN_WIDTH.
- COL_W, 9, column counter width; must satisfy 2^COL_W >= IN_WIDTH.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-low.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_en  output  1  FIFO pop request.
- fifo_valid  input  1  FIFO read data valid, one cycle after an accepted fifo_rd_en.
- fifo_dout  input  DATA_W  FIFO read data.
- out_valid  output  1  output pixel valid.
- out_data  output  DATA_W  output pixel.
- out_ready  input  1  downstream accepts when high with out_valid.
- row_dup  output  1  0 = live output row, 1 = replayed output row.

Behaviour:
- Reset (rst low, async): state=LIVE, col=0, dup=0, pix_vld=0, rd_pend=0. Outputs fifo_rd_en=0, out_valid=0, out_data=0, row_dup=0. Line buffer contents are don't-care.
- Mid-operation reset: aborts any row and any in-flight FIFO read; a fifo_valid arriving after reset release with rd_pend=0 is ignored.
- State LIVE (row_dup=0):
  - fifo_rd_en = !fifo_empty && !pix_vld && !rd_pend (combinational). A high fifo_rd_en sets rd_pend.
  - fifo_valid with rd_pend: pix<=fifo_dout, pix_vld<=1, linebuf[col]<=fifo_dout, rd_pend<=0.
  - out_valid=pix_vld, out_data=pix.
  - Handshake with dup=0: dup<=1.
  - Handshake with dup=1: dup<=0, pix_vld<=0, col<=col+1.
  - Handshake with dup=1 and col==IN_WIDTH-1: col<=0, state<=REPLAY.
- State REPLAY (row_dup=1):
  - fifo_rd_en=0; no prefetch, so the line buffer is never written while it is being replayed.
  - out_valid=1, out_data=linebuf[col] (combinational read).
  - Handshakes advance dup/col exactly as in LIVE; after the dup=1 beat at col==IN_WIDTH-1: col<=0, state<=LIVE.
- Latency: fifo_rd_en at cycle N, fifo_valid at N+1, out_valid at N+2.
- Live-row throughput: up to 2 outputs per 4 cycles. Replay throughput: 1 output per cycle.
- Backpressure: out_data and out_valid stay stable while out_valid && !out_ready. No FIFO read is issued while pix_vld=1.
- Empty FIFO in LIVE: out_valid stays low once pix is consumed; resumes when fifo_empty drops. No bubbles are inserted mid-pair.
- fifo_valid with rd_pend=0: ignored.
- The output pixel count per source row is exactly 4*IN_WIDTH. The column counter never exceeds IN_WIDTH-1.

Optional Feature:
- Macro UPSAMPLE_EOL_EN.
- Defined:
  - Adds output port out_eol (1 bit, reset 0).
  - out_eol = out_valid && dup==1 && col==IN_WIDTH-1, in both states; marks the last pixel of every output row.
  - Adds output port out_eof_pair (1 bit), high on the last pixel of a REPLAY row.
- Undefined: neither port exists; all other behaviour is identical.

Test Plan:
- IN_WIDTH=4, FIFO holds 10,20,30,40, out_ready=1 -> out_data sequence 10,10,20,20,30,30,40,40 with row_dup=0, then 10,10,20,20,30,30,40,40 with row_dup=1; exactly 4 fifo_rd_en pulses.
- Single pixel 0x55 with fifo_empty held high afterwards -> out_valid at exactly 2 cycles after fifo_rd_en; two 0x55 beats, then out_valid=0 with state LIVE, col=1.
- out_ready low for 5 cycles during the first beat of pixel 0xA3 -> out_data holds 0xA3, out_valid held high, fifo_rd_en=0 throughout; the beat completes on release.
- Random out_ready (50%) over 3 rows (IN_WIDTH=4) -> 48 output beats matching the reference model order; no lost or duplicated pixels.
- Assert rst low mid-REPLAY at col=2 -> next cycle out_valid=0, row_dup=0, fifo_rd_en=0; after release, the first FIFO pixel 0x07 is emitted as a new live row starting at col 0.
- UPSAMPLE_EOL_EN defined, IN_WIDTH=4 -> out_eol high on output beats 8 and 16; out_eof_pair high only on beat 16.
